// File: rtl/sid_env_sched.sv
// Time-multiplexed SID envelope scheduler: one shared ADSR step datapath walks all voices per tick.
// Optional sticky overrun flag built only when SID_ENV_SCHED_OVERRUN_EN is defined.
module sid_env_sched #(
  parameter int unsigned NVOICES = 3,
  parameter int unsigned RC_W    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_i,
  input  logic [8*NVOICES-1:0] attack_decay_i,
  input  logic [8*NVOICES-1:0] sust_release_i,
  input  logic [NVOICES-1:0]   gate_i,
  input  logic                 overrun_clr_i,
  output logic [8*NVOICES-1:0] env_out_o,
  output logic                 busy_o,
  output logic                 sweep_done_o,
  output logic                 overrun_o
);

  localparam int unsigned SlotW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [1:0] {AdsrAttack, AdsrDecay, AdsrRelease} adsr_e;

  state_e           state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic             sweep_done_q, sweep_done_d;
  logic             last_slot;

  logic [RC_W-1:0]  rate_cnt_q [NVOICES];
  logic [4:0]       exp_cnt_q  [NVOICES];
  adsr_e            adsr_q     [NVOICES];
  logic [3:0]       cur_rate_q [NVOICES];
  logic [7:0]       env_q      [NVOICES];
  logic [NVOICES-1:0] gate_last_q;

  // Selected-voice view and its next state
  logic [RC_W-1:0] sel_rc, rc_n, period;
  logic [4:0]      sel_exp, exp_n;
  adsr_e           sel_adsr, adsr_n;
  logic [3:0]      sel_rate, rate_n, sel_att, sel_dec, sel_sus, sel_rel;
  logic [7:0]      sel_env, env_n;
  logic            sel_gate, sel_gl, rise, fall, qualify, fire;

  function automatic logic [14:0] rate_period(input logic [3:0] r);
    logic [14:0] p;
    case (r)
      4'd0:    p = 15'd9;
      4'd1:    p = 15'd32;
      4'd2:    p = 15'd63;
      4'd3:    p = 15'd95;
      4'd4:    p = 15'd149;
      4'd5:    p = 15'd220;
      4'd6:    p = 15'd267;
      4'd7:    p = 15'd313;
      4'd8:    p = 15'd392;
      4'd9:    p = 15'd977;
      4'd10:   p = 15'd1954;
      4'd11:   p = 15'd3126;
      4'd12:   p = 15'd3907;
      4'd13:   p = 15'd11720;
      4'd14:   p = 15'd19532;
      default: p = 15'd31251;
    endcase
    return p;
  endfunction

  function automatic logic [4:0] exp_period(input logic [7:0] env);
    logic [4:0] p;
    if (env >= 8'h5E)      p = 5'd1;
    else if (env >= 8'h37) p = 5'd2;
    else if (env >= 8'h1B) p = 5'd4;
    else if (env >= 8'h0F) p = 5'd8;
    else if (env >= 8'h07) p = 5'd16;
    else if (env >= 8'h01) p = 5'd30;
    else                   p = 5'd1;
    return p;
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign last_slot = (slot_q == SlotW'(NVOICES - 1));

  // FSM: next state
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    sweep_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick_i) begin
          state_d = StRun;
          slot_d  = '0;
        end
      end
      StRun: begin
        if (last_slot) begin
          state_d      = StIdle;
          slot_d       = '0;
          sweep_done_d = 1'b1;
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o       = (state_q == StRun);
    sweep_done_o = sweep_done_q;
    for (int v = 0; v < NVOICES; v++) begin
      env_out_o[8*v +: 8] = env_q[v];
    end
  end

  // Shared datapath: mux in the slot's voice, compute its update
  always_comb begin
    sel_rc   = '0;
    sel_exp  = '0;
    sel_adsr = AdsrRelease;
    sel_rate = '0;
    sel_env  = '0;
    sel_gate = 1'b0;
    sel_gl   = 1'b0;
    sel_att  = '0;
    sel_dec  = '0;
    sel_sus  = '0;
    sel_rel  = '0;
    for (int v = 0; v < NVOICES; v++) begin
      if (slot_q == SlotW'(v)) begin
        sel_rc   = rate_cnt_q[v];
        sel_exp  = exp_cnt_q[v];
        sel_adsr = adsr_q[v];
        sel_rate = cur_rate_q[v];
        sel_env  = env_q[v];
        sel_gate = gate_i[v];
        sel_gl   = gate_last_q[v];
        sel_att  = attack_decay_i[8*v+4 +: 4];
        sel_dec  = attack_decay_i[8*v   +: 4];
        sel_sus  = sust_release_i[8*v+4 +: 4];
        sel_rel  = sust_release_i[8*v   +: 4];
      end
    end

    rise    = sel_gate & ~sel_gl;
    fall    = ~sel_gate & sel_gl;
    period  = RC_W'(rate_period(sel_rate));
    qualify = (sel_rc == period);
    // Rate counter keeps running across gate edges, as the real chip does
    rc_n    = qualify ? '0 : sel_rc + RC_W'(1);
    exp_n   = sel_exp;
    adsr_n  = sel_adsr;
    rate_n  = sel_rate;
    env_n   = sel_env;
    fire    = 1'b0;

    if (rise) begin
      adsr_n = AdsrAttack;
      rate_n = sel_att;
    end else if (fall) begin
      adsr_n = AdsrRelease;
      rate_n = sel_rel;
    end else begin
      if (sel_adsr == AdsrAttack) begin
        exp_n = '0;
        fire  = qualify;
      end else if (qualify) begin
        if (sel_exp == exp_period(sel_env)) begin
          exp_n = '0;
          fire  = 1'b1;
        end else begin
          exp_n = sel_exp + 5'd1;
        end
      end
      if (fire) begin
        case (sel_adsr)
          AdsrAttack: begin
            if (sel_env == 8'hFF) begin
              adsr_n = AdsrDecay;
              rate_n = sel_dec;
            end else begin
              env_n = sel_env + 8'd1;
            end
          end
          AdsrDecay: begin
            if (sel_env != {sel_sus, sel_sus} && sel_env != 8'h00) env_n = sel_env - 8'd1;
          end
          AdsrRelease: begin
            if (sel_env != 8'h00) env_n = sel_env - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-voice register banks; only the active slot is written
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_last_q <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        rate_cnt_q[v] <= '0;
        exp_cnt_q[v]  <= '0;
        adsr_q[v]     <= AdsrRelease;
        cur_rate_q[v] <= '0;
        env_q[v]      <= '0;
      end
    end else if (state_q == StRun) begin
      for (int v = 0; v < NVOICES; v++) begin
        if (slot_q == SlotW'(v)) begin
          rate_cnt_q[v]  <= rc_n;
          exp_cnt_q[v]   <= exp_n;
          adsr_q[v]      <= adsr_n;
          cur_rate_q[v]  <= rate_n;
          env_q[v]       <= env_n;
          gate_last_q[v] <= sel_gate;
        end
      end
    end
  end

`ifdef SID_ENV_SCHED_OVERRUN_EN
  logic overrun_q;

  // Set has priority over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (tick_i && state_q == StRun) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_q <= 1'b0;
    end
  end

  assign overrun_o = overrun_q;
`else
  logic unused_overrun_clr;
  assign unused_overrun_clr = overrun_clr_i;
  assign overrun_o          = 1'b0;
`endif

endmodule

// File: tb/tb_sid_env_sched.sv
// Scoreboard bench for sid_env_sched: expected env vectors queued per sweep, checked on sweep_done.
module tb_sid_env_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [23:0] ad = 24'h000000;
  logic [23:0] sr = 24'hA0A0A0;
  logic [2:0]  gate = 3'b000;
  logic [23:0] env_out;
  logic        busy, sweep_done, overrun;

  typedef struct {
    int unsigned sweep;
    logic [23:0] env;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_ticks = 0;
  int unsigned sweeps_seen = 0;
  int          gap_cyc = 5;
  logic        exp_ovr;

  always #5 clk = ~clk;

  sid_env_sched #(.NVOICES(3), .RC_W(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick_i         (tick),
    .attack_decay_i (ad),
    .sust_release_i (sr),
    .gate_i         (gate),
    .overrun_clr_i  (overrun_clr),
    .env_out_o      (env_out),
    .busy_o         (busy),
    .sweep_done_o   (sweep_done),
    .overrun_o      (overrun)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: one expected entry per numbered sweep
  always @(negedge clk) begin
    if (!reset && sweep_done) begin
      sweeps_seen++;
      while (sb_q.size() > 0 && sb_q[0].sweep < sweeps_seen) begin
        mon_e = sb_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL %s: sweep %0d skipped, expected env %h", mon_e.name, mon_e.sweep, mon_e.env);
      end
      if (sb_q.size() > 0 && sb_q[0].sweep == sweeps_seen) begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, {8'h00, env_out}, {8'h00, mon_e.env});
      end
    end
  end

  task automatic do_tick(input int gap, input bit chk, input logic [23:0] env, input string nm);
    exp_t e;
    if (chk) begin
      e.sweep = n_ticks + 1;
      e.env   = env;
      e.name  = nm;
      sb_q.push_back(e);
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
    n_ticks++;
  endtask

  task automatic run_plain(input int unsigned t);
    while (n_ticks < t) do_tick(gap_cyc, 1'b0, 24'h0, "");
  endtask

  task automatic run_to(input int unsigned t, input logic [23:0] env, input string nm);
    run_plain(t - 1);
    do_tick(gap_cyc, 1'b1, env, nm);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SID_ENV_SCHED_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_env", {8'h00, env_out}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, sweep_done}, 32'h0);
    check("reset_ovr", {31'h0, overrun}, 32'h0);

    // Attack at rate 0 with ticks landing on the sweep_done cycle
    gate    = 3'b001;
    gap_cyc = 4;
    run_to(9, 24'h000000, "att_t9");
    run_to(10, 24'h000001, "att_t10");
    run_to(12, 24'h000001, "att_t12");
    gap_cyc = 5;

    run_to(2550, 24'h0000FF, "att_peak");
    run_to(2560, 24'h0000FF, "att_to_decay");
    run_to(2579, 24'h0000FF, "decay_wait");
    run_to(2580, 24'h0000FE, "decay_first");
    run_to(4259, 24'h0000AB, "decay_near");
    run_to(4260, 24'h0000AA, "decay_sustain");

    // Voice1 up to 0x05 then slow exponential release
    run_plain(4300);
    gate = 3'b011;
    run_to(4309, 24'h0000AA, "v1_att_wait");
    run_to(4350, 24'h0005AA, "v1_att_5");
    gate = 3'b001;
    run_to(4351, 24'h0005AA, "v1_rel_edge");
    run_to(4659, 24'h0005AA, "v1_rel_hold");
    run_to(4660, 24'h0004AA, "v1_rel_step");
    run_to(5900, 24'h0000AA, "v1_rel_zero");
    run_to(6000, 24'h0000AA, "v1_rel_sat");

    // Gate bounce: rate counter keeps its phase, edge slot takes no step
    gate = 3'b011;
    run_to(6001, 24'h0000AA, "bounce_rise");
    gate = 3'b001;
    run_to(6002, 24'h0000AA, "bounce_fall");
    gate = 3'b011;
    run_to(6009, 24'h0000AA, "bounce_wait");
    run_to(6010, 24'h0001AA, "bounce_step");
    run_plain(6019);
    gate = 3'b001;
    run_to(6020, 24'h0001AA, "edge_no_step");
    gate = 3'b011;
    run_to(6030, 24'h0002AA, "edge_resume");

    // Tick while busy is dropped
    begin
      exp_t e;
      e.sweep = n_ticks + 1;
      e.env   = 24'h0002AA;
      e.name  = "drop_sweep";
      sb_q.push_back(e);
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("busy_t1", {31'h0, busy}, 32'h1);
    check("done_t1", {31'h0, sweep_done}, 32'h0);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("busy_t3", {31'h0, busy}, 32'h1);
    check("ovr_t3", {31'h0, overrun}, {31'h0, exp_ovr});
    @(negedge clk);
    check("busy_t4", {31'h0, busy}, 32'h0);
    check("done_t4", {31'h0, sweep_done}, 32'h1);
    @(negedge clk);
    check("done_t5", {31'h0, sweep_done}, 32'h0);
    check("busy_t5", {31'h0, busy}, 32'h0);
    n_ticks++;
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", {31'h0, overrun}, 32'h0);
    run_to(6039, 24'h0002AA, "drop_wait");
    run_to(6040, 24'h0003AA, "drop_step");

    // Reset during slot 1 aborts the sweep
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_env", {8'h00, env_out}, 32'h0);
    check("abort_done", {31'h0, sweep_done}, 32'h0);
    check("abort_ovr", {31'h0, overrun}, 32'h0);
    @(negedge clk);
    check("abort_done2", {31'h0, sweep_done}, 32'h0);
    @(negedge clk);
    check("abort_done3", {31'h0, sweep_done}, 32'h0);

    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s: no sweep_done seen, expected env %h", mon_e.name, mon_e.env);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
